// File: rtl/run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : run_sequencer
//  Purpose  : Launch controller that issues start pulses to a downstream
//             engine, waits for each done edge and repeats for a batch of
//             runs, with inter-run gap, per-run timeout watchdog and abort.
//  Revision : 1.0 - initial release
// ============================================================================
module run_sequencer #(
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int TMR_W          = 16,
    parameter int GAP_CYCLES     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [CNT_W-1:0] num_runs,
    input  logic             abort,
    input  logic             done_i,
    output logic             start_o,
    output logic             busy,
    output logic [CNT_W-1:0] run_count,
    output logic             all_done,
    output logic             timeout_err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYCLES - 1);

    logic [2:0]       state_q,     state_d;
    logic [TMR_W-1:0] timer_q,     timer_d;
    logic [CNT_W-1:0] target_q,    target_d;
    logic [CNT_W-1:0] run_count_q, run_count_d;
    logic             done_q,      done_d;

    logic             done_rise;
    logic [CNT_W-1:0] run_count_inc;
    logic             last_run;

    assign done_d        = done_i;
    assign done_rise     = done_i & ~done_q;
    assign run_count_inc = run_count_q + CNT_W'(1);
    assign last_run      = (run_count_inc == target_q);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; abort outranks every other transition
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_d = (num_runs != '0) ? S_LAUNCH : S_FINISH;
                    end
                end
                S_LAUNCH: state_d = S_WAIT;
                S_WAIT: begin
                    if (done_rise) begin
                        state_d = last_run ? S_FINISH : S_GAP;
                    end else if (timer_q == TMO_LAST) begin
                        state_d = S_ERROR;
                    end
                end
                S_GAP: begin
                    if (timer_q == GAP_LAST) begin
                        state_d = S_LAUNCH;
                    end
                end
                S_FINISH: state_d = S_IDLE;
                S_ERROR:  state_d = S_ERROR;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Output decode (Moore)
    always_comb begin
        start_o     = (state_q == S_LAUNCH);
        busy        = (state_q != S_IDLE);
        all_done    = (state_q == S_FINISH);
        timeout_err = (state_q == S_ERROR);
        run_count   = run_count_q;
    end

    // Datapath: timer is shared between the WAIT watchdog and the GAP counter
    always_comb begin
        timer_d     = timer_q;
        target_d    = target_q;
        run_count_d = run_count_q;
        if (!abort) begin
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        target_d    = num_runs;
                        run_count_d = '0;
                    end
                end
                S_LAUNCH: timer_d = '0;
                S_WAIT: begin
                    if (done_rise) begin
                        run_count_d = run_count_inc;
                        timer_d     = '0;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_GAP: timer_d = timer_q + TMR_W'(1);
                default: begin
                    timer_d = timer_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer_q     <= '0;
            target_q    <= '0;
            run_count_q <= '0;
            done_q      <= 1'b0;
        end else begin
            timer_q     <= timer_d;
            target_q    <= target_d;
            run_count_q <= run_count_d;
            done_q      <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_run_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_sequencer
//  Purpose  : Self-checking bench for run_sequencer with a run/timing model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_run_sequencer;

    localparam int CNT_W = 8;
    localparam int TMO   = 1000;
    localparam int TMR_W = 16;
    localparam int GAP   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             go;
    logic [CNT_W-1:0] num_runs;
    logic             abort;
    logic             done_i;
    logic             start_o;
    logic             busy;
    logic [CNT_W-1:0] run_count;
    logic             all_done;
    logic             timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_starts   = 0;
    int exp_alldone  = 0;
    int start_cnt    = 0;
    int wide_cnt     = 0;
    int alldone_cnt  = 0;
    logic start_prev = 1'b0;

    run_sequencer #(
        .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO), .TMR_W(TMR_W), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .reset(reset), .go(go), .num_runs(num_runs), .abort(abort),
        .done_i(done_i), .start_o(start_o), .busy(busy), .run_count(run_count),
        .all_done(all_done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Pulse bookkeeping sampled mid-cycle
    always @(negedge clk) begin
        if (start_o === 1'b1) begin
            start_cnt <= start_cnt + 1;
            if (start_prev === 1'b1) wide_cnt <= wide_cnt + 1;
        end
        if (all_done === 1'b1) alldone_cnt <= alldone_cnt + 1;
        start_prev <= start_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_start(input int bound, output int n);
        n = 0;
        while (start_o !== 1'b1 && n < bound) begin
            step(1);
            n++;
        end
    endtask

    task automatic wait_err(input int bound, output int n);
        n = 0;
        while (timeout_err !== 1'b1 && n < bound) begin
            step(1);
            n++;
        end
    endtask

    // One batch: dly=0 picks random done latencies; noise adds ignored go/done activity
    task automatic run_batch(input int n, input int dly, input bit noise);
        int d;
        int g;
        go = 1'b1; num_runs = CNT_W'(n);
        step(1);
        go = 1'b0;
        chk("launch_latency", start_o, 1);
        chk("launch_busy", busy, 1);
        chk("launch_rc_clear", run_count, 0);
        exp_starts++;
        for (int k = 0; k < n; k++) begin
            d = (dly != 0) ? dly : $urandom_range(1, 6);
            if (noise) begin
                go = 1'b1; num_runs = CNT_W'($urandom_range(1, 255));
            end
            step(d);
            go = 1'b0;
            chk("wait_rc_hold", run_count, k);
            chk("wait_start_low", start_o, 0);
            done_i = 1'b1;
            step(1);
            done_i = 1'b0;
            chk("run_count", run_count, k + 1);
            if (k == n - 1) begin
                chk("all_done", all_done, 1);
                exp_alldone++;
                step(1);
                chk("idle_after_batch", busy, 0);
                chk("all_done_one_cycle", all_done, 0);
            end else begin
                if (noise) begin
                    done_i = 1'b1;
                    step(1);
                    done_i = 1'b0;
                    wait_start(GAP + 8, g);
                    chk("gap_with_done_noise", g, GAP - 1);
                end else begin
                    wait_start(GAP + 8, g);
                    chk("gap_len", g, GAP);
                end
                chk("gap_rc_hold", run_count, k + 1);
                exp_starts++;
            end
        end
    endtask

    initial begin
        int g;
        reset = 1'b0; go = 1'b0; num_runs = '0; abort = 1'b0; done_i = 1'b0;
        step(2);
        chk("rst_busy", busy, 0);
        chk("rst_start", start_o, 0);
        chk("rst_rc", run_count, 0);
        chk("rst_all_done", all_done, 0);
        chk("rst_tmo", timeout_err, 0);
        reset = 1'b1;
        step(1);

        // Reset asserted mid-WAIT after one completed run
        go = 1'b1; num_runs = 8'd3;
        step(1);
        go = 1'b0; exp_starts++;
        step(2);
        done_i = 1'b1; step(1); done_i = 1'b0;
        chk("t1_rc_before", run_count, 1);
        wait_start(GAP + 8, g);
        exp_starts++;
        step(2);
        #3 reset = 1'b0;
        #1;
        chk("t1_busy", busy, 0);
        chk("t1_rc", run_count, 0);
        chk("t1_start", start_o, 0);
        chk("t1_tmo", {timeout_err, all_done}, 0);
        step(1);
        reset = 1'b1;
        step(1);
        chk("t1_idle", busy, 0);

        // Three runs, done 5 cycles after each start
        run_batch(3, 5, 1'b0);

        // Zero-length batch
        go = 1'b1; num_runs = '0;
        step(1);
        go = 1'b0;
        chk("t3_all_done", all_done, 1);
        chk("t3_start", start_o, 0);
        chk("t3_rc", run_count, 0);
        exp_alldone++;
        step(1);
        chk("t3_idle", busy, 0);

        // go together with abort in IDLE
        go = 1'b1; abort = 1'b1; num_runs = 8'd2;
        step(1);
        go = 1'b0; abort = 1'b0;
        chk("go_abort_idle", busy, 0);

        // Timeout with done never asserted
        go = 1'b1; num_runs = 8'd2;
        step(1);
        go = 1'b0; exp_starts++;
        wait_err(TMO + 20, g);
        chk("t4_tmo_cycles", g, TMO + 1);
        chk("t4_rc", run_count, 0);
        chk("t4_busy", busy, 1);
        go = 1'b1; num_runs = 8'd1;
        step(3);
        go = 1'b0;
        chk("t4_go_ignored", {timeout_err, start_o}, 2'b10);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t4_abort_tmo", timeout_err, 0);
        chk("t4_abort_busy", busy, 0);

        // Abort during GAP after run 2
        go = 1'b1; num_runs = 8'd4;
        step(1);
        go = 1'b0; exp_starts++;
        step(3);
        done_i = 1'b1; step(1); done_i = 1'b0;
        wait_start(GAP + 8, g);
        exp_starts++;
        step(2);
        done_i = 1'b1; step(1); done_i = 1'b0;
        chk("t5_rc_in_gap", run_count, 2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("t5_busy", busy, 0);
        chk("t5_no_all_done", all_done, 0);
        step(10);
        chk("t5_rc_hold", run_count, 2);
        chk("t5_no_restart", start_cnt, exp_starts);

        // Level-held done counts once per rising edge
        go = 1'b1; num_runs = 8'd2;
        step(1);
        go = 1'b0; exp_starts++;
        step(2);
        done_i = 1'b1;
        step(1);
        chk("t6_first", run_count, 1);
        wait_start(GAP + 8, g);
        chk("t6_gap_held", g, GAP);
        exp_starts++;
        step(4);
        chk("t6_held_no_count", run_count, 1);
        done_i = 1'b0;
        step(1);
        done_i = 1'b1;
        step(1);
        chk("t6_second", run_count, 2);
        chk("t6_all_done", all_done, 1);
        exp_alldone++;
        done_i = 1'b0;
        step(1);

        // done arriving in the final watchdog cycle wins over timeout
        go = 1'b1; num_runs = 8'd1;
        step(1);
        go = 1'b0; exp_starts++;
        step(TMO);
        chk("t6b_not_err_yet", timeout_err, 0);
        done_i = 1'b1;
        step(1);
        done_i = 1'b0;
        chk("t6b_rc", run_count, 1);
        chk("t6b_all_done", all_done, 1);
        chk("t6b_no_err", timeout_err, 0);
        exp_alldone++;
        step(1);

        // Randomized batches with ignored go/done activity
        for (int b = 0; b < 4; b++) begin
            run_batch($urandom_range(1, 5), 0, 1'b1);
            step($urandom_range(1, 4));
        end

        step(2);
        chk("start_total", start_cnt, exp_starts);
        chk("start_width", wide_cnt, 0);
        chk("all_done_total", alldone_cnt, exp_alldone);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
